// File: rtl/s_mixing.sv
// RC5 key-schedule mixing stage.
// Fills the S RAM with the magic-constant sequence P + i*Q, then runs
// 3*max(T,C) read-modify-write iterations over the S and L RAMs.
// When it finishes, S holds the expanded round-key table.
module s_mixing #(
  parameter int             W        = 32,
  parameter int             T        = 26,
  parameter int             C        = 4,
  parameter logic [W-1:0]   P        = 32'hB7E15163,
  parameter logic [W-1:0]   Q        = 32'h9E3779B9,
  parameter int             T_length = $clog2(T),
  parameter int             C_length = (C > 1) ? $clog2(C) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [T_length-1:0] S_address,
  input  logic [W-1:0]        S_sub_i,
  output logic [W-1:0]        S_sub_i_prima,
  output logic                S_we,
  output logic [C_length-1:0] L_address,
  input  logic [W-1:0]        L_sub_i,
  output logic [W-1:0]        L_sub_i_prima,
  output logic                L_we,
  output logic                busy,
  output logic                done
);

  localparam int SH = $clog2(W);
  localparam int N  = 3 * ((T > C) ? T : C);
  localparam int KW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RD   = 3'd2,
    CS   = 3'd3,
    CL   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                state_r;
  logic [W-1:0]          a_r;
  logic [W-1:0]          b_r;
  logic [W-1:0]          acc_r;
  logic [W-1:0]          l_cap_r;
  logic [T_length-1:0]   i_r;
  logic [C_length-1:0]   j_r;
  logic [KW-1:0]         k_r;

  logic [W-1:0]          ab_s;
  logic [W-1:0]          a_next_s;
  logic [W-1:0]          b_next_s;

  // Left rotate: the upper half of the doubled word shifted left by n.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SH-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  // Mixing arithmetic: A' from the S read in CS, B' from the captured L word and the fresh A in CL.
  always_comb begin
    ab_s     = a_r + b_r;
    a_next_s = rotl(S_sub_i + ab_s, SH'(3));
    b_next_s = rotl(l_cap_r + ab_s, ab_s[SH-1:0]);
  end

  // RAM port drive decoded from the current state; IDLE and DONE leave both ports quiet.
  always_comb begin
    S_address     = '0;
    S_sub_i_prima = '0;
    S_we          = 1'b0;
    L_address     = '0;
    L_sub_i_prima = '0;
    L_we          = 1'b0;
    case (state_r)
      INIT: begin
        S_we          = 1'b1;
        S_address     = i_r;
        S_sub_i_prima = acc_r;
      end
      RD: begin
        S_address = i_r;
        L_address = j_r;
      end
      CS: begin
        S_we          = 1'b1;
        S_address     = i_r;
        S_sub_i_prima = a_next_s;
        L_address     = j_r;
      end
      CL: begin
        L_we          = 1'b1;
        L_address     = j_r;
        L_sub_i_prima = b_next_s;
      end
      default: begin
        S_we = 1'b0;
        L_we = 1'b0;
      end
    endcase
  end

  // Schedule sequencer: state, mixing registers, indices and the busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      l_cap_r <= '0;
      i_r     <= '0;
      j_r     <= '0;
      k_r     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // busy trails the working states by one cycle so it spans exactly T+3N cycles
      busy <= (state_r == INIT) || (state_r == RD) || (state_r == CS) || (state_r == CL);
      case (state_r)
        IDLE, DONE: begin
          done <= (state_r == DONE) && !start;
          if (start) begin
            a_r     <= '0;
            b_r     <= '0;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            acc_r   <= P;
            state_r <= INIT;
          end else begin
            state_r <= state_r;
          end
        end
        INIT: begin
          acc_r <= acc_r + Q;
          if (i_r == T_length'(T - 1)) begin
            i_r     <= '0;
            state_r <= RD;
          end else begin
            i_r <= i_r + T_length'(1);
          end
        end
        RD: begin
          state_r <= CS;
        end
        CS: begin
          a_r     <= a_next_s;
          l_cap_r <= L_sub_i;
          state_r <= CL;
        end
        CL: begin
          b_r <= b_next_s;
          if (i_r == T_length'(T - 1)) begin
            i_r <= '0;
          end else begin
            i_r <= i_r + T_length'(1);
          end
          if (j_r == C_length'(C - 1)) begin
            j_r <= '0;
          end else begin
            j_r <= j_r + C_length'(1);
          end
          k_r <= k_r + KW'(1);
          if (k_r == KW'(N - 1)) begin
            state_r <= DONE;
          end else begin
            state_r <= RD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_mixing.sv
// Bench for s_mixing: three configurations (default, T=4/C=2/P=0/Q=1, T=2/C=1)
// each with its own registered-read RAM pair, checked against a plain
// RC5 key-schedule model that predicts every RAM write in order.
module tb_s_mixing;

  localparam logic [31:0] PD = 32'hB7E15163;
  localparam logic [31:0] QD = 32'h9E3779B9;
  localparam logic [31:0] PIN [10] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0,
                                      32'h8, 32'h800, 32'h4050, 32'h48500000};

  typedef struct {
    bit          is_s;
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst0, rst1, rst2;
  logic start0, start1, start2;
  logic [4:0]  sa0;  logic [31:0] sr0, sw0; logic swe0;
  logic [1:0]  la0;  logic [31:0] lr0, lw0; logic lwe0, busy0, done0;
  logic [1:0]  sa1;  logic [31:0] sr1, sw1; logic swe1;
  logic [0:0]  la1;  logic [31:0] lr1, lw1; logic lwe1, busy1, done1;
  logic [0:0]  sa2;  logic [31:0] sr2, sw2; logic swe2;
  logic [0:0]  la2;  logic [31:0] lr2, lw2; logic lwe2, busy2, done2;

  logic [31:0] sram0 [26]; logic [31:0] lram0 [4];
  logic [31:0] sram1 [4];  logic [31:0] lram1 [2];
  logic [31:0] sram2 [2];  logic [31:0] lram2 [1];

  logic [31:0] key_v [4];
  logic [2:0]  load_v;
  bit          mon_en;
  int          checks;
  int          errors;

  wr_t         exp_q [3][$];
  logic [31:0] model_s [3][26];
  logic [31:0] model_l [3][4];
  int          model_t [3];
  int          model_c [3];

  s_mixing u0 (.clk(clk), .rst(rst0), .start(start0),
    .S_address(sa0), .S_sub_i(sr0), .S_sub_i_prima(sw0), .S_we(swe0),
    .L_address(la0), .L_sub_i(lr0), .L_sub_i_prima(lw0), .L_we(lwe0),
    .busy(busy0), .done(done0));

  s_mixing #(.W(32), .T(4), .C(2), .P(32'h0), .Q(32'h1)) u1 (.clk(clk), .rst(rst1), .start(start1),
    .S_address(sa1), .S_sub_i(sr1), .S_sub_i_prima(sw1), .S_we(swe1),
    .L_address(la1), .L_sub_i(lr1), .L_sub_i_prima(lw1), .L_we(lwe1),
    .busy(busy1), .done(done1));

  s_mixing #(.W(32), .T(2), .C(1)) u2 (.clk(clk), .rst(rst2), .start(start2),
    .S_address(sa2), .S_sub_i(sr2), .S_sub_i_prima(sw2), .S_we(swe2),
    .L_address(la2), .L_sub_i(lr2), .L_sub_i_prima(lw2), .L_we(lwe2),
    .busy(busy2), .done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: registered read, write visible to the next cycle's read; load_v preloads L with key_v
  always @(posedge clk) begin
    if (load_v[0]) begin
      for (int t = 0; t < 4; t++) lram0[t] <= key_v[t];
      for (int t = 0; t < 26; t++) sram0[t] <= 32'h0;
    end else begin
      if (swe0) sram0[sa0] <= sw0;
      if (lwe0) lram0[la0] <= lw0;
      sr0 <= sram0[sa0];
      lr0 <= lram0[la0];
    end
    if (load_v[1]) begin
      for (int t = 0; t < 2; t++) lram1[t] <= key_v[t];
      for (int t = 0; t < 4; t++) sram1[t] <= 32'h0;
    end else begin
      if (swe1) sram1[sa1] <= sw1;
      if (lwe1) lram1[la1] <= lw1;
      sr1 <= sram1[sa1];
      lr1 <= lram1[la1];
    end
    if (load_v[2]) begin
      lram2[0] <= key_v[0];
      for (int t = 0; t < 2; t++) sram2[t] <= 32'h0;
    end else begin
      if (swe2) sram2[sa2] <= sw2;
      if (lwe2) lram2[la2] <= lw2;
      sr2 <= sram2[sa2];
      lr2 <= lram2[la2];
    end
  end

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s id=%0d got=%h want=%h", name, id, got, want);
    end
  endtask

  // Reference schedule: the textbook RC5 expansion, recording every RAM write in order.
  task automatic gen(input int id, input int tt, input int cc, input logic [31:0] p, input logic [31:0] q);
    logic [31:0] s [26];
    logic [31:0] l [4];
    logic [31:0] a, b;
    int i, j, n;
    exp_q[id].delete();
    for (int t = 0; t < tt; t++) begin
      s[t] = p + q * 32'(t);
      exp_q[id].push_back('{1'b1, t, s[t]});
    end
    for (int t = 0; t < cc; t++) l[t] = key_v[t];
    a = 32'h0; b = 32'h0; i = 0; j = 0;
    n = 3 * ((tt > cc) ? tt : cc);
    for (int k = 0; k < n; k++) begin
      a = rotl32(s[i] + a + b, 3);
      s[i] = a;
      exp_q[id].push_back('{1'b1, i, a});
      b = rotl32(l[j] + a + b, int'((a + b) & 32'd31));
      l[j] = b;
      exp_q[id].push_back('{1'b0, j, b});
      i = (i + 1) % tt;
      j = (j + 1) % cc;
    end
    for (int t = 0; t < tt; t++) model_s[id][t] = s[t];
    for (int t = 0; t < cc; t++) model_l[id][t] = l[t];
    model_t[id] = tt;
    model_c[id] = cc;
  endtask

  function automatic logic [31:0] ram_s(input int id, input int a);
    case (id)
      0:       return sram0[a];
      1:       return sram1[a];
      default: return sram2[a];
    endcase
  endfunction

  function automatic logic [31:0] ram_l(input int id, input int a);
    case (id)
      0:       return lram0[a];
      1:       return lram1[a];
      default: return lram2[0];
    endcase
  endfunction

  function automatic logic get_done(input int id);
    case (id)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(input int id);
    case (id)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [79:0] outs(input int id);
    case (id)
      0:       return 80'({sa0, sw0, swe0, la0, lw0, lwe0, busy0, done0});
      1:       return 80'({sa1, sw1, swe1, la1, lw1, lwe1, busy1, done1});
      default: return 80'({sa2, sw2, swe2, la2, lw2, lwe2, busy2, done2});
    endcase
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic check_zero(input int id);
    logic [79:0] v;
    v = outs(id);
    checks++;
    if (v !== 80'h0) begin
      errors++;
      $display("FAIL outputs_zero id=%0d got=%h want=0", id, v);
    end
  endtask

  // Per-cycle write checker: at most one write enable, and each write matches the next predicted one.
  task automatic check_port(input int id, input logic swe, input logic lwe, input int sa, input int la,
                            input logic [31:0] sw, input logic [31:0] lw);
    wr_t e;
    chk("single_we", id, 32'(swe & lwe), 32'h0);
    if (swe || lwe) begin
      if (exp_q[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_write id=%0d got=write want=none", id);
      end else begin
        e = exp_q[id].pop_front();
        chk("wr_kind", id, 32'(swe), 32'(e.is_s));
        chk("wr_addr", id, swe ? sa : la, e.addr);
        chk("wr_data", id, swe ? sw : lw, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_port(0, swe0, lwe0, int'(sa0), int'(la0), sw0, lw0);
        check_port(1, swe1, lwe1, int'(sa1), int'(la1), sw1, lw1);
        check_port(2, swe2, lwe2, int'(sa2), int'(la2), sw2, lw2);
      end
    end
  end

  task automatic preload(input int id);
    load_v[id] = 1'b1;
    @(posedge clk);
    #1 load_v[id] = 1'b0;
  endtask

  // One full schedule: preload, pulse start, time done and busy, then compare both RAMs to the model.
  task automatic run(input int id, input int lat, input bit noisy);
    int cnt, bc;
    bit seen;
    preload(id);
    set_start(id, 1'b1);
    @(posedge clk);
    #1 set_start(id, 1'b0);
    chk("done_drop", id, 32'(get_done(id)), 32'h0);
    chk("busy_first", id, 32'(get_busy(id)), 32'h0);
    cnt = 0; bc = 0; seen = 1'b0;
    while (!seen && cnt < lat + 10) begin
      @(posedge clk);
      #1 cnt++;
      if (get_done(id)) begin
        seen = 1'b1;
      end else begin
        bc += int'(get_busy(id));
        if (noisy) set_start(id, (cnt < lat - 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end
    set_start(id, 1'b0);
    chk("latency", id, cnt, lat);
    chk("busy_cycles", id, bc, lat - 1);
    chk("busy_at_done", id, 32'(get_busy(id)), 32'h0);
    chk("drained", id, exp_q[id].size(), 32'h0);
    for (int t = 0; t < model_t[id]; t++) chk("s_final", id, ram_s(id, t), model_s[id][t]);
    for (int t = 0; t < model_c[id]; t++) chk("l_final", id, ram_l(id, t), model_l[id][t]);
  endtask

  task automatic set_key(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] k2, input logic [31:0] k3);
    key_v[0] = k0; key_v[1] = k1; key_v[2] = k2; key_v[3] = k3;
  endtask

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0; load_v = 3'b000;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    set_key(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    for (int id = 0; id < 3; id++) check_zero(id);
    mon_en = 1'b1;

    // small configuration with hand-derived first writes
    gen(1, 4, 2, 32'h0, 32'h1);
    for (int t = 0; t < 10; t++) chk("model_pin", 1, exp_q[1][t].data, PIN[t]);
    run(1, 41, 1'b0);

    // default parameters, zero key; then again with start hammered while busy
    gen(0, 26, 4, PD, QD);
    run(0, 261, 1'b0);
    gen(0, 26, 4, PD, QD);
    run(0, 261, 1'b1);

    // abort with rst during the CS cycle of iteration 10, then a clean rerun
    gen(0, 26, 4, PD, QD);
    preload(0);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (57) @(posedge clk);
    #1 chk("abort_in_cs_we", 0, 32'(swe0), 32'h1);
    chk("abort_in_cs_addr", 0, 32'(sa0), 32'd10);
    rst0 = 1'b1;
    @(posedge clk);
    #1 check_zero(0);
    rst0 = 1'b0;
    exp_q[0].delete();
    @(posedge clk);
    #1 check_zero(0);
    gen(0, 26, 4, PD, QD);
    run(0, 261, 1'b0);

    // T=2, C=1: wrap and back-to-back L[0] read-after-write
    set_key(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    gen(2, 2, 1, PD, QD);
    run(2, 21, 1'b0);
    set_key($urandom, 32'h0, 32'h0, 32'h0);
    gen(2, 2, 1, PD, QD);
    run(2, 21, 1'b1);

    // key bytes 5..20 packed little-endian into L
    set_key(32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h14131211);
    gen(0, 26, 4, PD, QD);
    run(0, 261, 1'b0);

    // random keys
    for (int r = 0; r < 3; r++) begin
      set_key($urandom, $urandom, $urandom, $urandom);
      gen(0, 26, 4, PD, QD);
      run(0, 261, r[0]);
      gen(1, 4, 2, 32'h0, 32'h1);
      run(1, 41, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_mixing.md
Name: s_mixing

Overview:
- Key-expansion stage directly downstream of L_operation in the RC5 key schedule.
- On start, normally driven by L_operation's done, it first fills the S RAM with the magic-constant sequence.
- It then runs the RC5 mixing loop over S and L: 3*max(T,C) iterations, read-modify-write on both RAMs.
- When finished, the S RAM holds the expanded round-key table consumed by the encrypt/decrypt datapath.

Parameters:
- W, 32, word width in bits; power of two.
- T, 26, S-table size, 2*(r+1).
- C, 4, L-table size, b/u.
- P, 32'hB7E15163, magic constant Pw.
- Q, 32'h9E3779B9, magic constant Qw.
- T_length, $clog2(T), S address width.
- C_length, $clog2(C) (minimum 1), L address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin schedule; sampled only in IDLE.
- S_address  out  T_length  S RAM port-A address.
- S_sub_i  in  W  S RAM port-A read data.
- S_sub_i_prima  out  W  S RAM port-A write data.
- S_we  out  1  S RAM port-A write enable.
- L_address  out  C_length  L RAM port-A address.
- L_sub_i  in  W  L RAM port-A read data.
- L_sub_i_prima  out  W  L RAM port-A write data.
- L_we  out  1  L RAM port-A write enable.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  high in DONE; held until the next accepted start or rst.

Behaviour:
- RAM model: single-clock, registered read. An address driven in cycle n gives data in cycle n+1. A write in cycle n is visible to a read addressed in cycle n+1.
- Reset: state=IDLE. All outputs 0: S_address, L_address, S_sub_i_prima, L_sub_i_prima, S_we, L_we, busy, done. Internal A=B=0; i,j,k counters 0.
- rst has priority over everything. Asserting rst mid-operation aborts the schedule immediately; RAM contents are left partially updated.

State machine:
- IDLE: if start, clear A, B, i, j, k and go to INIT. Otherwise stay.
- DONE: behaves like IDLE on start, and drops done when start is accepted.
- INIT: one word per cycle. S_we=1, S_address=i, S_sub_i_prima=P+i*Q mod 2^W, kept in a running accumulator (no multiplier). Runs T cycles, i=0..T-1. After i=T-1: i=0, go to RD.
- RD: S_address=i, L_address=j, S_we=L_we=0. Go to CS.
- CS: A'=rotl(S_sub_i+A+B, 3). Drive S_we=1, S_address=i, S_sub_i_prima=A'. Register A<=A'. Go to CL.
- CL: B'=rotl(L_sub_i+A+B, (A+B) mod W), using the A updated in CS. Drive L_we=1, L_address=j, L_sub_i_prima=B'. Register B<=B'.
  - Update indices: i=(i+1) mod T, j=(j+1) mod C, k=k+1.
  - If k reaches N=3*max(T,C), go to DONE. Otherwise go to RD.
- L_sub_i must be captured in CS and held for CL. Alternatively the L address is held stable through CS; either is acceptable, but the result must equal the read of L[j] issued in RD.

Arithmetic and indexing:
- All additions are mod 2^W.
- Rotate amount is the low log2(W) bits of (A+B).
- i and j wrap independently. With C=1, the CL write of L[0] is visible to the next RD, per the RAM model.

Timing and handshakes:
- Latency: start sampled on edge E → done=1 from edge E+T+3N+1. Default: 26 + 234 = 260 cycles of busy.
- start while busy is ignored, with no effect on the schedule.
- start and DONE in the same cycle: restart occurs and done falls on the next edge.
- Exactly one write per cycle, and never S_we and L_we together.

Test Plan:
1. Small config W=32, T=4, C=2, P=0, Q=1, L RAM all 0, pulse start. Required:
   - INIT writes S = {0,1,2,3}.
   - First mixing writes: S0=0, L0=0, S1=8, L1=0x00000800, S2=0x00004050, L0=0x48500000.
   - done exactly 4+36+1 cycles after start is sampled.
2. Default parameters, 16-byte zero key (L=0). Required: final S[0..25] and L[0..3] match a C golden RC5-32/12/16 key schedule; busy high for 260 cycles.
3. Assert start repeatedly during the mixing phase. Required: RAM contents and done time are identical to scenario 2.
4. Assert rst at the cycle k=10, in CS. Required:
   - Next cycle all outputs are 0 and the state is IDLE.
   - A fresh start then reproduces scenario 2's results when the RAMs are re-preloaded.
5. Config T=2, C=1, L[0]=0xFFFFFFFF. Required:
   - Wrap of i and j, back-to-back L[0] read-after-write, and rotate-by-(A+B mod 32) including a rotate of 0 all match the golden model.
   - No cycle has S_we and L_we both high.
6. Chain L_operation → s_mixing, with start tied to L_operation's done and key bytes 5..20. Required: final S table matches the golden model for that key.
